if_fetch_buf: RTL and testbench

Instruction-fetch stage placed directly downstream of the PC register. Each cycle it accepts the current PC and issues a single-outstanding request/acknowledge fetch to instruction memory. Fetched {pc, instruction} pairs go into a small FIFO that feeds the IF/ID pipeline register. When it cannot accept a PC it raises a stall request to the pipeline controller, and it squashes wrong-path work on a branch.

---
 rtl/if_fetch_buf_if.sv | 26 ++
 rtl/if_fetch_buf.sv | 101 ++++++++++
 tb/tb_if_fetch_buf.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_buf_if.sv
// Fetch-stage bundle: PC/pipeline control in, instruction-memory handshake,
// and the FIFO head presented to the IF/ID register.
interface if_fetch_buf_if;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        branch_flag_i;
  logic [5:0]  stall;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ack_i;
  logic [31:0] inst_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        stallreq_o;

  modport master (
    input  pc_i, ce_i, branch_flag_i, stall, inst_ack_i, inst_rdata_i,
    output inst_req_o, inst_addr_o, if_valid_o, if_pc_o, if_inst_o, stallreq_o
  );

  modport slave (
    output pc_i, ce_i, branch_flag_i, stall, inst_ack_i, inst_rdata_i,
    input  inst_req_o, inst_addr_o, if_valid_o, if_pc_o, if_inst_o, stallreq_o
  );
endinterface

// File: rtl/if_fetch_buf.sv
// Instruction-fetch buffer: single-outstanding memory fetch feeding a small
// {pc, inst} FIFO toward IF/ID, with stall request and branch squash.
module if_fetch_buf #(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_buf_if.master bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DISCARD} state_t;

  state_t          state_q, state_d;
  logic            busy, discard;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   cnt_q;
  entry_t          mem_q [DEPTH];
  logic            ack, pop, push, can_accept, accept, fifo_valid;
  logic [CW:0]     credit;
  logic            unused_stall;

  assign unused_stall = ^bus.stall[5:2];

  // Handshake and flow-control decisions for this cycle
  assign ack        = bus.inst_ack_i & busy;
  assign fifo_valid = (cnt_q != '0);
  assign pop        = fifo_valid & ~bus.stall[1] & ~bus.branch_flag_i;
  assign push       = ack & ~discard & ~bus.branch_flag_i;
  // Slots already spoken for: buffered entries plus a live in-flight fetch
  assign credit     = {1'b0, cnt_q} + (CW+1)'(busy & ~discard) - (CW+1)'(pop);
  assign can_accept = (~busy | bus.inst_ack_i) & (credit < (CW+1)'(DEPTH));
  assign accept     = bus.ce_i & ~bus.branch_flag_i & ~bus.stall[0] & can_accept;
  assign bus.stallreq_o = bus.ce_i & ~bus.branch_flag_i & ~can_accept;

  // Request FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Request FSM: next state; a branch with an unacked fetch marks it for drop
  always_comb begin
    state_d = state_q;
    if (accept)                            state_d = S_BUSY;
    else if (ack)                          state_d = S_IDLE;
    else if (busy && bus.branch_flag_i)    state_d = S_DISCARD;
  end

  // Request FSM: outputs decoded from the state register
  always_comb begin
    busy           = 1'b0;
    discard        = 1'b0;
    bus.inst_req_o = 1'b0;
    case (state_q)
      S_BUSY:    begin busy = 1'b1; bus.inst_req_o = 1'b1; end
      S_DISCARD: begin busy = 1'b1; discard = 1'b1; bus.inst_req_o = 1'b1; end
      default:   ;
    endcase
  end

  // Request address held stable until the next accept
  always_ff @(posedge clk) begin
    if (rst)         bus.inst_addr_o <= '0;
    else if (accept) bus.inst_addr_o <= bus.pc_i;
  end

  // FIFO pointers and occupancy; a branch flushes everything
  always_ff @(posedge clk) begin
    if (rst || bus.branch_flag_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{pc: bus.inst_addr_o, inst: bus.inst_rdata_i};
  end

  // Head outputs come only from storage, never bypassed from memory data
  assign bus.if_valid_o = fifo_valid;
  assign bus.if_pc_o    = fifo_valid ? mem_q[head_q].pc   : '0;
  assign bus.if_inst_o  = fifo_valid ? mem_q[head_q].inst : '0;

endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed bench for if_fetch_buf: PC register and memory responder around
// the DUT, cycle-by-cycle checks of stream, waits, full FIFO, branch, reset.
module tb_if_fetch_buf;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_buf_if bus ();

  if_fetch_buf #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int          age;
  int          wait_cyc;
  int          watch_hits = 0;
  logic        stall1, stall0_ext, hold, force_ack;
  logic [31:0] pc_reg, br_target;

  // Controller folds the fetch stall request into the PC hold
  assign bus.stall = {4'b0000, stall1, stall0_ext | bus.stallreq_o};
  assign bus.pc_i  = pc_reg;

  always @(posedge clk) begin
    if (rst)                                   pc_reg <= '0;
    else if (bus.branch_flag_i)                pc_reg <= br_target;
    else if (bus.ce_i && !bus.stall[0])        pc_reg <= pc_reg + 32'd4;
  end

  // Memory: acks after wait_cyc cycles of request, data derived from address
  always @(posedge clk) begin
    if (rst || !bus.inst_req_o || bus.inst_ack_i) age <= 0;
    else                                          age <= age + 1;
  end

  always_comb begin
    bus.inst_ack_i   = force_ack | (bus.inst_req_o & ~hold & (age >= wait_cyc));
    bus.inst_rdata_i = bus.inst_addr_o ^ KEY;
  end

  always @(posedge clk) begin
    if (!rst && bus.inst_req_o && bus.inst_ack_i && bus.inst_addr_o == 32'h114)
      watch_hits <= watch_hits + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; bus.ce_i = 1'b0; bus.branch_flag_i = 1'b0;
    stall1 = 1'b0; stall0_ext = 1'b0; hold = 1'b0; force_ack = 1'b0;
    wait_cyc = 0; br_target = '0;
    repeat (2) @(posedge clk);
    #1;

    // cycle 0: reset state with fetching enabled
    rst = 1'b0; bus.ce_i = 1'b1;
    @(negedge clk);
    chk("rst_req",      bus.inst_req_o,  0);
    chk("rst_addr",     bus.inst_addr_o, 0);
    chk("rst_valid",    bus.if_valid_o,  0);
    chk("rst_pc",       bus.if_pc_o,     0);
    chk("rst_inst",     bus.if_inst_o,   0);
    chk("rst_stallreq", bus.stallreq_o,  0);

    // cycle 1: first request out
    step(); @(negedge clk);
    chk("c1_req",   bus.inst_req_o,  1);
    chk("c1_addr",  bus.inst_addr_o, 0);
    chk("c1_valid", bus.if_valid_o,  0);

    // cycles 2..9: one instruction per cycle
    for (int k = 2; k <= 9; k++) begin
      step(); @(negedge clk);
      chk("zw_valid",    bus.if_valid_o, 1);
      chk("zw_pc",       bus.if_pc_o,    32'((k - 2) * 4));
      chk("zw_inst",     bus.if_inst_o,  32'((k - 2) * 4) ^ KEY);
      chk("zw_stallreq", bus.stallreq_o, 0);
    end

    // cycles 10..14: IF/ID held, FIFO fills
    step(); stall1 = 1'b1; @(negedge clk);
    chk("full10_pc", bus.if_pc_o, 32'h20);
    chk("full10_sr", bus.stallreq_o, 0);
    step(); @(negedge clk);
    chk("full11_pc", bus.if_pc_o, 32'h20);
    chk("full11_sr", bus.stallreq_o, 0);
    step(); @(negedge clk);
    chk("full12_sr",   bus.stallreq_o,  1);
    chk("full12_req",  bus.inst_req_o,  1);
    chk("full12_addr", bus.inst_addr_o, 32'h2C);
    step(); @(negedge clk);
    chk("full13_sr",  bus.stallreq_o, 1);
    chk("full13_req", bus.inst_req_o, 0);
    chk("full13_pc",  bus.if_pc_o,    32'h20);
    step(); @(negedge clk);
    chk("full14_sr",  bus.stallreq_o, 1);
    chk("full14_req", bus.inst_req_o, 0);

    // cycles 15..20: drain in order while fetching resumes
    step(); stall1 = 1'b0; @(negedge clk);
    chk("drain15_sr", bus.stallreq_o, 0);
    chk("drain15_pc", bus.if_pc_o,    32'h20);
    for (int k = 16; k <= 20; k++) begin
      step(); @(negedge clk);
      chk("drain_valid", bus.if_valid_o, 1);
      chk("drain_pc",    bus.if_pc_o,    32'h20 + 32'((k - 15) * 4));
      chk("drain_sr",    bus.stallreq_o, 0);
    end

    // cycle 21: branch to 0x100 while 0x44 is outstanding and unacked
    step(); bus.branch_flag_i = 1'b1; br_target = 32'h100; hold = 1'b1;
    @(negedge clk);
    chk("br21_sr",   bus.stallreq_o,  0);
    chk("br21_addr", bus.inst_addr_o, 32'h44);
    step(); bus.branch_flag_i = 1'b0; @(negedge clk);
    chk("br22_valid", bus.if_valid_o,  0);
    chk("br22_sr",    bus.stallreq_o,  1);
    chk("br22_req",   bus.inst_req_o,  1);
    chk("br22_addr",  bus.inst_addr_o, 32'h44);
    step(); @(negedge clk);
    chk("br23_sr", bus.stallreq_o, 1);
    step(); hold = 1'b0; @(negedge clk);
    chk("br24_sr",    bus.stallreq_o, 0);
    chk("br24_valid", bus.if_valid_o, 0);
    step(); @(negedge clk);
    chk("br25_req",   bus.inst_req_o,  1);
    chk("br25_addr",  bus.inst_addr_o, 32'h100);
    chk("br25_valid", bus.if_valid_o,  0);
    step(); @(negedge clk);
    chk("br26_valid", bus.if_valid_o, 1);
    chk("br26_pc",    bus.if_pc_o,    32'h100);
    chk("br26_inst",  bus.if_inst_o,  32'h100 ^ KEY);

    // cycles 27..32: two wait states per fetch
    step(); wait_cyc = 2; @(negedge clk);
    chk("ws27_sr",   bus.stallreq_o,  1);
    chk("ws27_addr", bus.inst_addr_o, 32'h108);
    chk("ws27_pc",   bus.if_pc_o,     32'h104);
    step(); @(negedge clk);
    chk("ws28_sr",    bus.stallreq_o,  1);
    chk("ws28_addr",  bus.inst_addr_o, 32'h108);
    chk("ws28_valid", bus.if_valid_o,  0);
    step(); @(negedge clk);
    chk("ws29_sr",   bus.stallreq_o,  0);
    chk("ws29_addr", bus.inst_addr_o, 32'h108);
    step(); @(negedge clk);
    chk("ws30_sr",    bus.stallreq_o,  1);
    chk("ws30_addr",  bus.inst_addr_o, 32'h10C);
    chk("ws30_valid", bus.if_valid_o,  1);
    chk("ws30_pc",    bus.if_pc_o,     32'h108);
    step(); @(negedge clk);
    chk("ws31_sr",    bus.stallreq_o, 1);
    chk("ws31_valid", bus.if_valid_o, 0);
    step(); @(negedge clk);
    chk("ws32_sr",   bus.stallreq_o,  0);
    chk("ws32_addr", bus.inst_addr_o, 32'h10C);

    // cycles 33..37: external PC stall, held PC 0x114 fetched once
    step(); wait_cyc = 0; stall0_ext = 1'b1; @(negedge clk);
    chk("ps33_sr",   bus.stallreq_o,  0);
    chk("ps33_pc",   bus.if_pc_o,     32'h10C);
    chk("ps33_addr", bus.inst_addr_o, 32'h110);
    step(); @(negedge clk);
    chk("ps34_req", bus.inst_req_o, 0);
    chk("ps34_pc",  bus.if_pc_o,    32'h110);
    step(); @(negedge clk);
    chk("ps35_req",   bus.inst_req_o, 0);
    chk("ps35_valid", bus.if_valid_o, 0);
    chk("ps35_sr",    bus.stallreq_o, 0);
    step(); stall0_ext = 1'b0; @(negedge clk);
    chk("ps36_req", bus.inst_req_o, 0);
    step(); @(negedge clk);
    chk("ps37_req",  bus.inst_req_o,  1);
    chk("ps37_addr", bus.inst_addr_o, 32'h114);

    // cycles 38..40: two buffered, one stuck outstanding, then reset
    step(); stall1 = 1'b1; @(negedge clk);
    chk("rm38_addr", bus.inst_addr_o, 32'h118);
    chk("rm38_pc",   bus.if_pc_o,     32'h114);
    step(); hold = 1'b1; @(negedge clk);
    chk("once_0x114", 32'(watch_hits), 1);
    chk("rm39_sr",    bus.stallreq_o,  1);
    chk("rm39_addr",  bus.inst_addr_o, 32'h11C);
    chk("rm39_pc",    bus.if_pc_o,     32'h114);
    step(); rst = 1'b1; @(negedge clk);
    chk("rm40_req", bus.inst_req_o, 1);

    // cycles 41..45: everything cleared, late ack ignored, restart at 0
    step(); rst = 1'b0; bus.ce_i = 1'b0; force_ack = 1'b1; hold = 1'b0; stall1 = 1'b0;
    @(negedge clk);
    chk("rm41_req",   bus.inst_req_o,  0);
    chk("rm41_addr",  bus.inst_addr_o, 0);
    chk("rm41_valid", bus.if_valid_o,  0);
    chk("rm41_pc",    bus.if_pc_o,     0);
    chk("rm41_inst",  bus.if_inst_o,   0);
    chk("rm41_sr",    bus.stallreq_o,  0);
    step(); force_ack = 1'b0; @(negedge clk);
    chk("rm42_req",   bus.inst_req_o, 0);
    chk("rm42_valid", bus.if_valid_o, 0);
    step(); bus.ce_i = 1'b1; @(negedge clk);
    chk("rm43_sr",  bus.stallreq_o, 0);
    chk("rm43_req", bus.inst_req_o, 0);
    step(); @(negedge clk);
    chk("rm44_req",  bus.inst_req_o,  1);
    chk("rm44_addr", bus.inst_addr_o, 0);
    step(); @(negedge clk);
    chk("rm45_valid", bus.if_valid_o, 1);
    chk("rm45_pc",    bus.if_pc_o,    0);
    chk("rm45_inst",  bus.if_inst_o,  KEY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
